// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch
//  Purpose  : Instruction-fetch stage. Owns the fetch PC, issues sequential
//             word requests to instruction memory (valid/ready request,
//             in-order responses), buffers returned words in a small FIFO and
//             drives the if_id__ registers consumed by decode. Handles
//             load-use stalls from decode and flush/redirect from execute;
//             responses still in flight at a flush are discarded.
//  Ports    :
//    clk                 in   clock, rising edge
//    rst                 in   asynchronous reset, active-high
//    pipe_flush          in   redirect to jump_target, kill everything in flight
//    jump_target[31:0]   in   redirect address (bits [1:0] forced to 0)
//    data_hazard         in   decode stall request (load-use)
//    imem_req_valid      out  request valid
//    imem_req_ready      in   memory accepts the request this cycle
//    imem_req_addr[31:0] out  word address of the request
//    imem_rsp_valid      in   response valid (in request order, latency >= 1)
//    imem_rsp_data[31:0] in   instruction word
//    if_id__ins[31:0]    out  instruction to decode
//    if_id__pc[31:0]     out  PC of if_id__ins
//    if_id__data_hazard  out  registered data_hazard, decode bubbles on it
//  Revision : 1.0  initial release
// ============================================================================
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_flush,
  input  logic [31:0] jump_target,
  input  logic        data_hazard,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_id__ins,
  output logic [31:0] if_id__pc,
  output logic        if_id__data_hazard
);

  localparam logic [31:0] c_NOP       = 32'h00000013;
  localparam logic [31:0] c_BUBBLE_PC = 32'hffffffff;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = CW + 2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   if_ins_q, if_ins_d;
  logic [31:0]   if_pc_q, if_pc_d;
  logic          if_dh_q, if_dh_d;

  logic [31:0]   fifo_ins_q [DEPTH];
  logic [31:0]   fifo_pc_q  [DEPTH];

  // --------------------------------------------------------------------------
  // Handshake / control decode
  // --------------------------------------------------------------------------
  logic [SW-1:0] w_credit_used;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_drop;
  logic          w_rsp_acc;
  logic          w_rsp_used;
  logic          w_fifo_empty;
  logic          w_advance;
  logic          w_pop;
  logic          w_bypass;
  logic          w_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Every in-flight, doomed or buffered instruction consumes one credit, so
  // the FIFO can never overflow when a response lands.
  assign w_credit_used = SW'(outstanding_q) + SW'(drop_q) + SW'(fifo_count_q);
  assign w_req_valid   = !rst && !pipe_flush && (w_credit_used < SW'(DEPTH));
  assign w_req_fire    = w_req_valid && imem_req_ready;

  // A response with nothing tracked (protocol error) matches neither term
  // and is ignored.
  assign w_rsp_drop    = imem_rsp_valid && (drop_q != '0);
  assign w_rsp_acc     = imem_rsp_valid && (drop_q == '0) && (outstanding_q != '0);
  assign w_rsp_used    = w_rsp_drop || w_rsp_acc;

  assign w_fifo_empty  = (fifo_count_q == '0);
  assign w_advance     = !pipe_flush && !data_hazard;
  assign w_pop         = w_advance && !w_fifo_empty;
  assign w_bypass      = w_advance && w_fifo_empty && w_rsp_acc;
  assign w_push        = !pipe_flush && w_rsp_acc && !w_bypass;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    fifo_count_d  = fifo_count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if_ins_d      = if_ins_q;
    if_pc_d       = if_pc_q;
    if_dh_d       = if_dh_q;

    if (pipe_flush) begin
      fetch_pc_d    = {jump_target[31:2], 2'b00};
      rsp_pc_d      = {jump_target[31:2], 2'b00};
      // Everything still owed by memory becomes doomed. Any response that
      // arrives in this cycle (live or already doomed) retires one of them.
      drop_d        = drop_q + outstanding_q - CW'(w_rsp_used);
      outstanding_d = '0;
      fifo_count_d  = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      if_ins_d      = c_NOP;
      if_pc_d       = c_BUBBLE_PC;
      if_dh_d       = 1'b0;
    end else begin
      if (w_req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CW'(w_req_fire) - CW'(w_rsp_acc);
      drop_d        = drop_q - CW'(w_rsp_drop);
      if (w_rsp_acc) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end

      fifo_count_d = fifo_count_q + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (w_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      if (data_hazard) begin
        if_dh_d = 1'b1;
      end else begin
        if_dh_d = 1'b0;
        if (w_pop) begin
          if_ins_d = fifo_ins_q[rd_ptr_q];
          if_pc_d  = fifo_pc_q[rd_ptr_q];
        end else if (w_bypass) begin
          if_ins_d = imem_rsp_data;
          if_pc_d  = rsp_pc_q;
        end else begin
          if_ins_d = c_NOP;
          if_pc_d  = c_BUBBLE_PC;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifo_count_q  <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      if_ins_q      <= c_NOP;
      if_pc_q       <= c_BUBBLE_PC;
      if_dh_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifo_count_q  <= fifo_count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if_ins_q      <= if_ins_d;
      if_pc_q       <= if_pc_d;
      if_dh_q       <= if_dh_d;
    end
  end

  // FIFO storage carries no reset: an entry is only read after it was
  // written, as tracked by fifo_count_q. When full, a simultaneous push and
  // pop hit the same slot; the pop reads the old word before the edge.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_ins_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]  <= rsp_pc_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_req_valid     = w_req_valid;
  assign imem_req_addr      = fetch_pc_q;
  assign if_id__ins         = if_ins_q;
  assign if_id__pc          = if_pc_q;
  assign if_id__data_hazard = if_dh_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch
//  Purpose  : Self-checking bench for fetch. A behavioural memory returns
//             responses in order after a configurable latency; a queue-based
//             reference model predicts the request channel and the if_id
//             registers every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch;

  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] BUB      = 32'hffffffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_flush;
  logic [31:0] jump_target;
  logic        data_hazard;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] if_id__ins;
  logic [31:0] if_id__pc;
  logic        if_id__data_hazard;

  fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .pipe_flush         (pipe_flush),
    .jump_target        (jump_target),
    .data_hazard        (data_hazard),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .if_id__ins         (if_id__ins),
    .if_id__pc          (if_id__pc),
    .if_id__data_hazard (if_id__data_hazard)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- memory environment ----------------
  typedef struct { logic [31:0] addr; int t; } mreq_t;
  mreq_t mq[$];
  int cyc     = 0;
  int last_t  = 0;
  int lat_min = 1;
  int lat_max = 1;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h13579bdf;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; bit live; } fl_t;
  typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
  fl_t         m_fl[$];   // requests owed by memory, oldest first
  ent_t        m_buf[$];  // instructions returned but not yet handed to decode
  logic [31:0] m_fpc, m_ins, m_pc;
  bit          m_dh;

  function automatic void model_reset();
    m_fl.delete();
    m_buf.delete();
    mq.delete();
    m_fpc = RESET_PC;
    m_ins = NOP;
    m_pc  = BUB;
    m_dh  = 1'b0;
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit fl, input logic [31:0] tgt, input bit hz, input bit rdy);
    bit    exp_v;
    bit    have;
    ent_t  got;
    fl_t   f;
    mreq_t r;
    int    t;
    pipe_flush     = fl;
    jump_target    = tgt;
    data_hazard    = hz;
    imem_req_ready = rdy;
    if (mq.size() > 0 && mq[0].t <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memw(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    chk("if_id__ins", if_id__ins, m_ins);
    chk("if_id__pc", if_id__pc, m_pc);
    chk("if_id__data_hazard", {31'd0, if_id__data_hazard}, {31'd0, m_dh});
    exp_v = !fl && (m_fl.size() + m_buf.size() < DEPTH);
    chk("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, exp_v});
    if (exp_v) chk("imem_req_addr", imem_req_addr, m_fpc);

    // model update for the coming edge
    have = 1'b0;
    got  = '{ins: 32'd0, pc: 32'd0};
    if (imem_rsp_valid && m_fl.size() > 0) begin
      f = m_fl.pop_front();
      if (f.live) begin
        have   = 1'b1;
        got.ins = imem_rsp_data;
        got.pc  = f.addr;
      end
    end
    if (fl) begin
      foreach (m_fl[i]) m_fl[i].live = 1'b0;
      m_buf.delete();
      m_fpc = {tgt[31:2], 2'b00};
      m_ins = NOP;
      m_pc  = BUB;
      m_dh  = 1'b0;
    end else begin
      if (exp_v && rdy) begin
        f.addr = m_fpc;
        f.live = 1'b1;
        m_fl.push_back(f);
        m_fpc = m_fpc + 32'd4;
      end
      if (have) m_buf.push_back(got);
      if (hz) begin
        m_dh = 1'b1;
      end else begin
        m_dh = 1'b0;
        if (m_buf.size() > 0) begin
          got   = m_buf.pop_front();
          m_ins = got.ins;
          m_pc  = got.pc;
        end else begin
          m_ins = NOP;
          m_pc  = BUB;
        end
      end
    end

    // memory environment: retire the delivered response, record a new request
    if (imem_rsp_valid) r = mq.pop_front();
    if (imem_req_valid && rdy) begin
      t = cyc + int'($urandom_range(lat_max, lat_min));
      if (t <= last_t) t = last_t + 1;
      r.addr = imem_req_addr;
      r.t    = t;
      mq.push_back(r);
      last_t = t;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    pipe_flush     = 1'b0;
    data_hazard    = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    jump_target    = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    last_t = cyc;
  endtask

  // Wait (bounded) for the first non-bubble instruction after a redirect.
  task automatic wait_real(input string name, input logic [31:0] want_pc);
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (if_id__pc !== BUB) found = 1'b1;
      else step(1'b0, 32'd0, 1'b0, 1'b1);
    end
    chk({name, "_bound"}, {31'd0, found}, 32'd1);
    chk({name, "_pc"}, if_id__pc, want_pc);
    chk({name, "_ins"}, if_id__ins, memw(want_pc));
  endtask

  typedef struct { bit hz; logic [31:0] exp_pc; bit exp_dh; } vec_t;
  vec_t vt[9];

  initial begin
    // zero-wait stream with a one-cycle load-use stall while if_id__pc=0x8
    vt[0] = '{1'b0, BUB,   1'b0};
    vt[1] = '{1'b0, BUB,   1'b0};
    vt[2] = '{1'b0, 32'h0, 1'b0};
    vt[3] = '{1'b0, 32'h4, 1'b0};
    vt[4] = '{1'b1, 32'h8, 1'b0};
    vt[5] = '{1'b0, 32'h8, 1'b1};
    vt[6] = '{1'b0, 32'hC, 1'b0};
    vt[7] = '{1'b0, 32'h10, 1'b0};
    vt[8] = '{1'b0, 32'h14, 1'b0};

    // reset values
    rst = 1'b1; pipe_flush = 1'b0; data_hazard = 1'b0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; jump_target = 32'd0;
    #1;
    chk("rst_ins", if_id__ins, NOP);
    chk("rst_pc", if_id__pc, BUB);
    chk("rst_dh", {31'd0, if_id__data_hazard}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // table-driven zero-wait sequence
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 9; i++) begin
      chk("tbl_pc", if_id__pc, vt[i].exp_pc);
      chk("tbl_dh", {31'd0, if_id__data_hazard}, {31'd0, vt[i].exp_dh});
      step(1'b0, 32'd0, vt[i].hz, 1'b1);
    end

    // flush with two requests outstanding, 3-cycle memory
    do_reset();
    lat_min = 3; lat_max = 3;
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h103, 1'b0, 1'b1);
    chk("flush_pc", if_id__pc, BUB);
    wait_real("flush_first", 32'h100);
    repeat (4) step(1'b0, 32'd0, 1'b0, 1'b1);

    // flush in the same cycle as a response and a hazard
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (5) step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    chk("fhz_dh", {31'd0, if_id__data_hazard}, 32'd0);
    chk("fhz_ins", if_id__ins, NOP);
    chk("fhz_pc", if_id__pc, BUB);
    wait_real("fhz_first", 32'h200);

    // memory not ready for 5 cycles
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 32'd0, 1'b0, 1'b1);

    // asynchronous reset mid-stream with one request outstanding
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ins", if_id__ins, NOP);
    chk("async_rst_pc", if_id__pc, BUB);
    chk("async_rst_dh", {31'd0, if_id__data_hazard}, 32'd0);
    chk("async_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    do_reset();
    pipe_flush = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_req_addr", imem_req_addr, RESET_PC);
    repeat (6) step(1'b0, 32'd0, 1'b0, 1'b1);

    // randomized traffic against the reference model
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
